// File: rtl/cache_fill_arbiter.sv
// Shared memory port: store > D-miss > I-miss; a miss streams a whole block, one read per cycle, fills steered to the owner.
// First mem_en one cycle after the grant edge; requesters hold until done/ack. Optional CRITICAL_WORD_FIRST_EN starts at the missed word.
module cache_fill_arbiter #(
    parameter int BLOCK_WORDS = 8
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           i_miss_req,
    input  logic [15:0]                    i_miss_addr,
    input  logic                           d_miss_req,
    input  logic [15:0]                    d_miss_addr,
    input  logic                           d_wr_req,
    input  logic [15:0]                    d_wr_addr,
    input  logic [15:0]                    d_wr_data,
    output logic                           mem_en,
    output logic                           mem_wr,
    output logic [15:0]                    mem_addr,
    output logic [15:0]                    mem_wdata,
    input  logic [15:0]                    mem_rdata,
    input  logic                           mem_rvalid,
    output logic                           i_fill_we,
    output logic                           d_fill_we,
    output logic [$clog2(BLOCK_WORDS)-1:0] fill_word,
    output logic [15:0]                    fill_data,
    output logic                           i_fill_done,
    output logic                           d_fill_done,
    output logic                           d_wr_ack,
    output logic                           busy
);
    localparam int WW = $clog2(BLOCK_WORDS);
    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_WRITE = 2'd1;
    localparam logic [1:0] S_FILL  = 2'd2;
    localparam logic [15:0] OFS_MASK = 16'(2 * BLOCK_WORDS - 1);

    logic [1:0]    state;
    logic          owner_d;
    logic [15:0]   base;
    logic [WW:0]   issue_cnt;
    logic [WW-1:0] recv_cnt;
    logic [WW-1:0] issue_word;
    logic [WW-1:0] recv_word;
    logic [15:0]   grant_addr;
    logic          fill_grant;
    logic          issuing;
    logic          fill_hit;
    logic          last_word;

    assign grant_addr = d_miss_req ? d_miss_addr : i_miss_addr;
    assign fill_grant = (state == S_IDLE) && !d_wr_req && (d_miss_req || i_miss_req);
    assign issuing    = (state == S_FILL) && (issue_cnt < (WW+1)'(BLOCK_WORDS));
    assign fill_hit   = (state == S_FILL) && mem_rvalid;
    assign last_word  = (recv_cnt == WW'(BLOCK_WORDS - 1));

`ifdef CRITICAL_WORD_FIRST_EN
    logic [WW-1:0] w0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            w0 <= '0;
        end else if (fill_grant) begin
            w0 <= grant_addr[WW:1];
        end
    end

    // Word index wraps naturally in WW bits, giving the modulo-block order.
    assign issue_word = w0 + issue_cnt[WW-1:0];
    assign recv_word  = w0 + recv_cnt;
`else
    assign issue_word = issue_cnt[WW-1:0];
    assign recv_word  = recv_cnt;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            owner_d   <= 1'b0;
            base      <= '0;
            issue_cnt <= '0;
            recv_cnt  <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (d_wr_req) begin
                        state <= S_WRITE;
                    end else if (fill_grant) begin
                        state     <= S_FILL;
                        owner_d   <= d_miss_req;
                        base      <= grant_addr & ~OFS_MASK;
                        issue_cnt <= '0;
                        recv_cnt  <= '0;
                    end
                end
                S_WRITE: state <= S_IDLE;
                S_FILL: begin
                    if (issuing) begin
                        issue_cnt <= issue_cnt + (WW+1)'(1);
                    end
                    if (mem_rvalid) begin
                        recv_cnt <= recv_cnt + WW'(1);
                        if (last_word) begin
                            state <= S_IDLE;
                        end
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    always_comb begin
        mem_en    = 1'b0;
        mem_wr    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        d_wr_ack  = 1'b0;
        if (state == S_WRITE) begin
            mem_en    = 1'b1;
            mem_wr    = 1'b1;
            mem_addr  = d_wr_addr;
            mem_wdata = d_wr_data;
            d_wr_ack  = 1'b1;
        end else if (issuing) begin
            mem_en   = 1'b1;
            mem_addr = base + {{(15-WW){1'b0}}, issue_word, 1'b0};
        end
    end

    // Fill side is combinational on mem_rvalid so the cache writes the word the cycle it arrives.
    assign i_fill_we   = fill_hit && !owner_d;
    assign d_fill_we   = fill_hit && owner_d;
    assign fill_word   = fill_hit ? recv_word : '0;
    assign fill_data   = fill_hit ? mem_rdata : '0;
    assign i_fill_done = i_fill_we && last_word;
    assign d_fill_done = d_fill_we && last_word;
    assign busy        = (state != S_IDLE);

endmodule
